uart_stream_master: RTL and testbench

Hardware initiator for the UART register interface (divider reg plus data reg with wait/re handshake). Turns the UART register port into valid/ready byte streams so non-CPU logic (boot loader, debug console, test pattern source) can own the UART without a bus master. Programs the baud divider after reset, forwards TX bytes honouring reg_dat_wait, and drains RX bytes into a small FIFO.

---
 rtl/uart_stream_pkg.sv | 25 ++
 rtl/uart_stream_master_if.sv | 32 +++
 rtl/uart_stream_fifo.sv | 69 ++++++
 rtl/uart_stream_master.sv | 145 ++++++++++++++
 tb/tb_uart_stream_master.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_stream_pkg.sv
// rtl/uart_stream_pkg.sv - shared types and constants for the UART stream master
//
// Holds the TX FSM state encoding, the UART "no byte pending" read word,
// the ASCII codes used by the optional CR/LF expansion (UART_STREAM_CRLF_EN)
// and a helper that decides whether a data-register read carries a byte.
package uart_stream_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    CR   = 2'd2,
    SEND = 2'd3
  } state_e;

  localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;
  localparam logic [7:0]  ASCII_CR      = 8'h0D;
  localparam logic [7:0]  ASCII_LF      = 8'h0A;

  // The UART returns {24'h0, byte} when a byte is pending and all-ones
  // otherwise, so the upper 24 bits alone tell the two apart.
  function automatic logic is_byte_word(input logic [31:0] word);
    return (word[31:8] == 24'h0);
  endfunction

endpackage

// File: rtl/uart_stream_master_if.sv
// rtl/uart_stream_master_if.sv - UART register port bundle
//
// Signals:
//   reg_div_we   [3:0]  divider byte write enables      (master -> UART)
//   reg_div_di   [31:0] divider write data              (master -> UART)
//   reg_dat_we          data write request              (master -> UART)
//   reg_dat_re          data read strobe                (master -> UART)
//   reg_dat_di   [31:0] data write word {24'h0, byte}   (master -> UART)
//   reg_dat_do   [31:0] data read word                  (UART -> master)
//   reg_dat_wait        UART stalls the current write   (UART -> master)
// Modports: master (the stream block), slave (the UART).
interface uart_stream_master_if;

  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  modport master (
    output reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
    input  reg_dat_do, reg_dat_wait
  );

  modport slave (
    input  reg_div_we, reg_div_di, reg_dat_we, reg_dat_re, reg_dat_di,
    output reg_dat_do, reg_dat_wait
  );

endinterface

// File: rtl/uart_stream_fifo.sv
// rtl/uart_stream_fifo.sv - synchronous FIFO holding received UART bytes
//
// Ports:
//   clk, resetn        clock, asynchronous active-low reset (clears pointers)
//   push, push_data    write request and data (ignored when full)
//   pop                read request (ignored when empty)
//   pop_data           head entry, valid when !empty
//   full, empty        occupancy flags
//   level              occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2.
module uart_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so the count reaches DEPTH exactly when its MSB sets.
  assign full     = count[AW];
  assign empty    = (count == '0);
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally at DEPTH because they are exactly AW bits wide.
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_stream_master.sv
// rtl/uart_stream_master.sv - UART register initiator exposing TX/RX byte streams
//
// Programs the baud divider once after reset, forwards TX bytes to the UART
// data register honouring reg_dat_wait, and drains received bytes into a FIFO.
// Optional feature macro: UART_STREAM_CRLF_EN (expand LF into CR, LF on TX).
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   tx_valid/tx_ready/tx_data   TX byte stream in
//   rx_valid/rx_ready/rx_data   RX byte stream out (FIFO head)
//   rx_level                    RX FIFO occupancy
//   busy                        init not done or TX byte pending
//   bus                         UART register port (master modport)
module uart_stream_master
  import uart_stream_pkg::*;
#(
  parameter logic [31:0] CLK_DIV       = 32'd104,
  parameter int          RX_FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             tx_valid,
  output logic                             tx_ready,
  input  logic [7:0]                       tx_data,
  output logic                             rx_valid,
  input  logic                             rx_ready,
  output logic [7:0]                       rx_data,
  output logic [$clog2(RX_FIFO_DEPTH):0]   rx_level,
  output logic                             busy,
  uart_stream_master_if.master             bus
);

  state_e state;
  logic   fifo_full;
  logic   fifo_empty;
  logic   write_done;

  assign write_done = bus.reg_dat_we && !bus.reg_dat_wait;

  // ---------------------------------------------------------------------------
  // TX FSM. tx_ready and busy are registered alongside the state so they track
  // it exactly. INIT spends two cycles: one presenting the divider write and
  // one leaving, so the divider strobe is visible while state is still INIT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= INIT;
      bus.reg_div_we <= 4'h0;
      bus.reg_div_di <= 32'h0;
      bus.reg_dat_we <= 1'b0;
      bus.reg_dat_di <= 32'h0;
      tx_ready       <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          if (bus.reg_div_we == 4'h0) begin
            bus.reg_div_we <= 4'hF;
            bus.reg_div_di <= CLK_DIV;
          end else begin
            bus.reg_div_we <= 4'h0;
            state          <= IDLE;
            tx_ready       <= 1'b1;
            busy           <= 1'b0;
          end
        end

        IDLE: begin
          if (tx_valid) begin
            tx_ready       <= 1'b0;
            busy           <= 1'b1;
            bus.reg_dat_we <= 1'b1;
`ifdef UART_STREAM_CRLF_EN
            if (tx_data == ASCII_LF) begin
              state          <= CR;
              bus.reg_dat_di <= {24'h0, ASCII_CR};
            end else begin
              state          <= SEND;
              bus.reg_dat_di <= {24'h0, tx_data};
            end
`else
            state          <= SEND;
            bus.reg_dat_di <= {24'h0, tx_data};
`endif
          end
        end

`ifdef UART_STREAM_CRLF_EN
        // The inserted CR completes under the same wait rule, then the LF
        // itself goes out through SEND without releasing reg_dat_we.
        CR: begin
          if (write_done) begin
            state          <= SEND;
            bus.reg_dat_di <= {24'h0, ASCII_LF};
          end
        end
`endif

        SEND: begin
          // No timeout: the first write after a divider change can stall for
          // a whole dummy frame, and any later stall is equally legitimate.
          if (write_done) begin
            state          <= IDLE;
            bus.reg_dat_we <= 1'b0;
            tx_ready       <= 1'b1;
            busy           <= 1'b0;
          end
        end

        default: begin
          state          <= INIT;
          bus.reg_div_we <= 4'h0;
          bus.reg_dat_we <= 1'b0;
          tx_ready       <= 1'b0;
          busy           <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX path, independent of the TX FSM. The read strobe is combinational so a
  // pending byte is captured in the same cycle it is seen; the UART clears its
  // valid flag on that edge. When the FIFO is full the byte stays in the UART.
  // ---------------------------------------------------------------------------
  assign bus.reg_dat_re = is_byte_word(bus.reg_dat_do) && !fifo_full && (state != INIT);

  uart_stream_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (bus.reg_dat_re),
    .push_data (bus.reg_dat_do[7:0]),
    .pop       (rx_valid && rx_ready),
    .pop_data  (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (rx_level)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_stream_master.sv
// tb/tb_uart_stream_master.sv - self-checking bench for uart_stream_master
module tb_uart_stream_master;
  import uart_stream_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int NVEC  = 18;

`ifdef UART_STREAM_CRLF_EN
  localparam int LF_WRITES = 2;
`else
  localparam int LF_WRITES = 1;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [7:0]    tx_data = 8'h00;
  logic          rx_valid;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic [LW-1:0] rx_level;
  logic          busy;

  uart_stream_master_if bus ();

  uart_stream_master #(
    .CLK_DIV       (32'd104),
    .RX_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_level (rx_level),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  int          div_pulses = 0;
  logic [31:0] wr_log[$];

  // Observe the UART side at the edge: divider strobes and completed writes.
  always @(posedge clk) begin
    if (bus.reg_div_we != 4'h0) div_pulses++;
    if (bus.reg_dat_we && !bus.reg_dat_wait) wr_log.push_back(bus.reg_dat_di);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_ready(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && tx_ready !== 1'b1; i++) step();
    check(name, {31'h0, tx_ready}, 32'h1);
  endtask

  typedef struct {
    logic [31:0]   dat_do;
    logic          rdy;
    logic          exp_re;
    logic [LW-1:0] exp_lvl;
    logic [7:0]    exp_head;
  } rx_vec_t;

  rx_vec_t vecs [NVEC];
  int      bad;

  initial begin
    vecs[0]  = '{32'h0000_0055, 1'b0, 1'b1, 3'd1, 8'h55};
    vecs[1]  = '{RX_EMPTY_WORD, 1'b0, 1'b0, 3'd1, 8'h55};
    vecs[2]  = '{RX_EMPTY_WORD, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[3]  = '{32'h0000_0001, 1'b0, 1'b1, 3'd1, 8'h01};
    vecs[4]  = '{32'h0000_0002, 1'b0, 1'b1, 3'd2, 8'h01};
    vecs[5]  = '{32'h0000_0003, 1'b0, 1'b1, 3'd3, 8'h01};
    vecs[6]  = '{32'h0000_0004, 1'b0, 1'b1, 3'd4, 8'h01};
    vecs[7]  = '{32'h0000_0005, 1'b0, 1'b0, 3'd4, 8'h01};
    vecs[8]  = '{32'h0000_0005, 1'b0, 1'b0, 3'd4, 8'h01};
    vecs[9]  = '{32'h0000_0005, 1'b1, 1'b0, 3'd3, 8'h02};
    vecs[10] = '{32'h0000_0005, 1'b0, 1'b1, 3'd4, 8'h02};
    vecs[11] = '{RX_EMPTY_WORD, 1'b1, 1'b0, 3'd3, 8'h03};
    vecs[12] = '{RX_EMPTY_WORD, 1'b1, 1'b0, 3'd2, 8'h04};
    vecs[13] = '{RX_EMPTY_WORD, 1'b1, 1'b0, 3'd1, 8'h05};
    vecs[14] = '{RX_EMPTY_WORD, 1'b1, 1'b0, 3'd0, 8'h00};
    vecs[15] = '{32'h0000_0077, 1'b0, 1'b1, 3'd1, 8'h77};
    vecs[16] = '{32'h0000_0088, 1'b1, 1'b1, 3'd1, 8'h88};
    vecs[17] = '{RX_EMPTY_WORD, 1'b1, 1'b0, 3'd0, 8'h00};

    // Reset state, with a byte already offered by the UART.
    bus.reg_dat_do   = 32'h0000_0033;
    bus.reg_dat_wait = 1'b0;
    repeat (3) step();
    check("rst_div_we",   {28'h0, bus.reg_div_we}, 32'h0);
    check("rst_div_di",   bus.reg_div_di, 32'h0);
    check("rst_dat_we",   {31'h0, bus.reg_dat_we}, 32'h0);
    check("rst_dat_re",   {31'h0, bus.reg_dat_re}, 32'h0);
    check("rst_dat_di",   bus.reg_dat_di, 32'h0);
    check("rst_tx_ready", {31'h0, tx_ready}, 32'h0);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_rx_level", {29'h0, rx_level}, 32'h0);
    check("rst_busy",     {31'h0, busy}, 32'h1);

    // Divider programming: one INIT cycle with the strobe, then IDLE.
    resetn = 1'b1;
    step();
    check("init_div_we",   {28'h0, bus.reg_div_we}, 32'hF);
    check("init_div_di",   bus.reg_div_di, 32'd104);
    check("init_tx_ready", {31'h0, tx_ready}, 32'h0);
    check("init_busy",     {31'h0, busy}, 32'h1);
    check("init_re_low",   {31'h0, bus.reg_dat_re}, 32'h0);
    step();
    bus.reg_dat_do = RX_EMPTY_WORD;
    check("idle_div_we",   {28'h0, bus.reg_div_we}, 32'h0);
    check("idle_tx_ready", {31'h0, tx_ready}, 32'h1);
    check("idle_busy",     {31'h0, busy}, 32'h0);
    repeat (3) step();
    check("div_pulses", div_pulses, 32'd1);

    // TX 0x41 stalled for 50 cycles.
    wr_log.delete();
    tx_valid = 1'b1;
    tx_data = 8'h41;
    bus.reg_dat_wait = 1'b1;
    step();
    tx_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(bus.reg_dat_we === 1'b1 && bus.reg_dat_di === 32'h41 &&
            tx_ready === 1'b0 && busy === 1'b1)) bad++;
      step();
    end
    check("tx_stall_stable", bad, 32'd0);
    bus.reg_dat_wait = 1'b0;
    check("tx_last_we", {31'h0, bus.reg_dat_we}, 32'h1);
    check("tx_last_di", bus.reg_dat_di, 32'h41);
    step();
    check("tx_done_we",    {31'h0, bus.reg_dat_we}, 32'h0);
    check("tx_done_ready", {31'h0, tx_ready}, 32'h1);
    check("tx_done_busy",  {31'h0, busy}, 32'h0);
    check("tx_writes",     wr_log.size(), 32'd1);
    if (wr_log.size() > 0) check("tx_word", wr_log[0], 32'h41);

    // RX table: single byte, fill to full, blocked byte, drain, push+pop.
    for (int i = 0; i < NVEC; i++) begin
      bus.reg_dat_do = vecs[i].dat_do;
      rx_ready = vecs[i].rdy;
      #1;
      check($sformatf("rx%0d_re", i), {31'h0, bus.reg_dat_re}, {31'h0, vecs[i].exp_re});
      step();
      check($sformatf("rx%0d_level", i), {29'h0, rx_level}, {29'h0, vecs[i].exp_lvl});
      check($sformatf("rx%0d_valid", i), {31'h0, rx_valid}, {31'h0, (vecs[i].exp_lvl != '0)});
      if (vecs[i].exp_lvl != '0)
        check($sformatf("rx%0d_head", i), {24'h0, rx_data}, {24'h0, vecs[i].exp_head});
    end
    rx_ready = 1'b0;
    bus.reg_dat_do = RX_EMPTY_WORD;

    // RX bytes arriving while TX is stalled in SEND.
    wr_log.delete();
    tx_valid = 1'b1;
    tx_data = 8'h5A;
    bus.reg_dat_wait = 1'b1;
    step();
    tx_valid = 1'b0;
    bus.reg_dat_do = 32'h0000_00A0;
    step();
    bus.reg_dat_do = 32'h0000_00A1;
    step();
    bus.reg_dat_do = RX_EMPTY_WORD;
    step();
    check("cc_rx_level", {29'h0, rx_level}, 32'd2);
    check("cc_head0",    {24'h0, rx_data}, 32'hA0);
    check("cc_tx_we",    {31'h0, bus.reg_dat_we}, 32'h1);
    check("cc_tx_di",    bus.reg_dat_di, 32'h5A);
    rx_ready = 1'b1;
    step();
    check("cc_head1", {24'h0, rx_data}, 32'hA1);
    step();
    check("cc_empty", {29'h0, rx_level}, 32'd0);
    rx_ready = 1'b0;
    bus.reg_dat_wait = 1'b0;
    wait_tx_ready("cc_tx_ready", 20);
    check("cc_tx_writes", wr_log.size(), 32'd1);
    if (wr_log.size() > 0) check("cc_tx_word", wr_log[0], 32'h5A);

    // LF: expanded to CR, LF only when the feature is built in.
    wr_log.delete();
    tx_valid = 1'b1;
    tx_data = ASCII_LF;
    bus.reg_dat_wait = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (2) step();
    bus.reg_dat_wait = 1'b0;
    wait_tx_ready("lf_tx_ready", 20);
    check("lf_writes_at_ready", wr_log.size(), LF_WRITES);
    if (wr_log.size() == LF_WRITES) begin
`ifdef UART_STREAM_CRLF_EN
      check("lf_word0", wr_log[0], {24'h0, ASCII_CR});
      check("lf_word1", wr_log[1], {24'h0, ASCII_LF});
`else
      check("lf_word0", wr_log[0], {24'h0, ASCII_LF});
`endif
    end

    // Reset while a byte is held in SEND drops it immediately.
    tx_valid = 1'b1;
    tx_data = 8'h33;
    bus.reg_dat_wait = 1'b1;
    step();
    tx_valid = 1'b0;
    check("mid_send_we", {31'h0, bus.reg_dat_we}, 32'h1);
    resetn = 1'b0;
    #1;
    check("mid_rst_we",    {31'h0, bus.reg_dat_we}, 32'h0);
    check("mid_rst_di",    bus.reg_dat_di, 32'h0);
    check("mid_rst_ready", {31'h0, tx_ready}, 32'h0);
    check("mid_rst_busy",  {31'h0, busy}, 32'h1);
    bus.reg_dat_wait = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
